// File: rtl/fast_pkg.sv
// Shared definitions for the FAST ring fetcher:
// the radius-3 Bresenham ring offsets and the fetch FSM states.
package fast_pkg;

    localparam int RING_LEN = 16;
    localparam int SLOTS    = RING_LEN + 1;

    localparam logic [4:0] LAST_IDX = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fetch_state_t;

    // Ring pixel k (1..16) lives at entry k-1.
    localparam logic signed [3:0] RING_DX [RING_LEN] = '{
        4'sd0,  4'sd1,  4'sd2,  4'sd3,
        4'sd3,  4'sd3,  4'sd2,  4'sd1,
        4'sd0,  -4'sd1, -4'sd2, -4'sd3,
        -4'sd3, -4'sd3, -4'sd2, -4'sd1
    };

    localparam logic signed [3:0] RING_DY [RING_LEN] = '{
        -4'sd3, -4'sd3, -4'sd2, -4'sd1,
        4'sd0,  4'sd1,  4'sd2,  4'sd3,
        4'sd3,  4'sd3,  4'sd2,  4'sd1,
        4'sd0,  -4'sd1, -4'sd2, -4'sd3
    };

endpackage

// File: rtl/fast_ring_fetch.sv
// Fetches a center pixel plus its 16-pixel FAST ring from the image SRAM
// and hands all 17 pixels to the scorer in one valid/ready transfer.
module fast_ring_fetch
    import fast_pkg::*;
#(
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX       = 16,
    parameter int Y_MAX       = 16,
    localparam int XW         = $clog2(X_MAX) + 1,
    localparam int YW         = $clog2(Y_MAX) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [XW-1:0]                cx,
    input  logic [YW-1:0]                cy,
    output logic [XW-1:0]                x_addr,
    output logic [YW-1:0]                y_addr,
    output logic                         ren,
    output logic                         wen,
    output logic [PIXEL_DEPTH-1:0]       wdat,
    input  logic [PIXEL_DEPTH-1:0]       rdat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PIXEL_DEPTH-1:0]       center_px,
    output logic [RING_LEN*PIXEL_DEPTH-1:0] ring_px,
    output logic                         busy
);

    localparam logic [XW-1:0] X_LIM = XW'(X_MAX - 1);
    localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX - 1);

    fetch_state_t state, state_nx;

    logic [4:0]    idx;
    logic [XW-1:0] cx_q;
    logic [YW-1:0] cy_q;

    logic signed [3:0] dx, dy;
    logic [3:0]        slot;
    logic [XW:0]       x_sum;
    logic [YW:0]       y_sum;
    logic              oob;
    logic              accept;

    logic              cap_vld;
    logic [4:0]        cap_idx;
    logic              cap_oob;

    logic [PIXEL_DEPTH-1:0] px_q [SLOTS];

    assign wen  = 1'b0;
    assign wdat = '0;

    assign accept = start_valid & start_ready;

    // Ring entry for the current slot; slot 0 is the center itself.
    always_comb begin
        slot = idx[3:0] - 4'd1;
        dx   = 4'sd0;
        dy   = 4'sd0;
        if (idx != 5'd0) begin
            dx = RING_DX[slot];
            dy = RING_DY[slot];
        end
    end

    // Center plus offset with one guard bit so the bounds test sees the true sign.
    always_comb begin
        x_sum = {cx_q[XW-1], cx_q} + {{(XW-3){dx[3]}}, dx};
        y_sum = {cy_q[YW-1], cy_q} + {{(YW-3){dy[3]}}, dy};
        oob   = 1'b0;
        if (x_sum[XW] || (x_sum[XW-1:0] > X_LIM)) begin
            oob = 1'b1;
        end
        if (y_sum[YW] || (y_sum[YW-1:0] > Y_LIM)) begin
            oob = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and image-port / handshake outputs.
    always_comb begin
        state_nx    = state;
        start_ready = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        ren         = 1'b0;
        x_addr      = '0;
        y_addr      = '0;
        unique case (state)
            IDLE: begin
                busy        = 1'b0;
                start_ready = ~rst;
                if (start_valid && !rst) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                ren    = ~oob;
                x_addr = x_sum[XW-1:0];
                y_addr = y_sum[YW-1:0];
                if (idx == LAST_IDX) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Center latch and issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            cx_q <= '0;
            cy_q <= '0;
        end else if (accept) begin
            idx  <= '0;
            cx_q <= cx;
            cy_q <= cy;
        end else if (state == ISSUE) begin
            if (idx == LAST_IDX) begin
                idx <= '0;
            end else begin
                idx <= idx + 5'd1;
            end
        end
    end

    // Track which slot the returning read data belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld <= 1'b0;
            cap_idx <= '0;
            cap_oob <= 1'b0;
        end else begin
            cap_vld <= (state == ISSUE);
            cap_idx <= idx;
            cap_oob <= oob;
        end
    end

    // Capture read data, forcing off-image slots to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                px_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (cap_vld && (cap_idx == 5'(i))) begin
                    px_q[i] <= cap_oob ? '0 : rdat;
                end
            end
        end
    end

    // Pack the ring into the parallel output bus.
    always_comb begin
        center_px = px_q[0];
        ring_px   = '0;
        for (int k = 0; k < RING_LEN; k++) begin
            ring_px[k*PIXEL_DEPTH +: PIXEL_DEPTH] = px_q[k+1];
        end
    end

endmodule

// File: tb/tb_fast_ring_fetch.sv
// Bench for fast_ring_fetch: image SRAM model, scoreboard of expected
// ring results, and directed corner / handshake / reset scenarios.
module tb_fast_ring_fetch;

    localparam int PD = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [4:0]   cx, cy;
    logic [4:0]   x_addr, y_addr;
    logic         ren, wen;
    logic [7:0]   wdat, rdat;
    logic         out_valid, out_ready;
    logic [7:0]   center_px;
    logic [127:0] ring_px;
    logic         busy;

    fast_ring_fetch #(
        .PIXEL_DEPTH(PD),
        .X_MAX(16),
        .Y_MAX(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .cx(cx),
        .cy(cy),
        .x_addr(x_addr),
        .y_addr(y_addr),
        .ren(ren),
        .wen(wen),
        .wdat(wdat),
        .rdat(rdat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .center_px(center_px),
        .ring_px(ring_px),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic bit inb(int x, int y);
        return (x >= 0) && (x <= 15) && (y >= 0) && (y <= 15);
    endfunction

    function automatic logic [7:0] pix(int x, int y);
        logic [7:0] v;
        v = '0;
        if (inb(x, y)) v = {y[3:0], x[3:0]};
        return v;
    endfunction

    // Image SRAM: one-cycle read latency, garbage when not reading.
    always @(posedge clk) begin
        if (ren && inb($signed(x_addr), $signed(y_addr)))
            rdat <= pix($signed(x_addr), $signed(y_addr));
        else
            rdat <= 8'($urandom);
    end

    typedef struct {
        logic [7:0]   c;
        logic [127:0] r;
        int           acc;
    } exp_t;

    exp_t sb[$];

    int dxs[16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int dys[16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    function automatic exp_t model(int x, int y, int acc);
        exp_t e;
        e.c   = pix(x, y);
        e.r   = '0;
        e.acc = acc;
        for (int k = 0; k < 16; k++)
            e.r[k*8 +: 8] = pix(x + dxs[k], y + dys[k]);
        return e;
    endfunction

    bit           seen = 0;
    bit           hs_prev = 0;
    bit           b2b = 0;
    int           n_b2b = 0;
    int           last_hs = -100;
    logic [7:0]   last_c;
    logic [127:0] last_r;

    // Monitor: sample between edges, score outputs, push expectations.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            seen = 0;
            hs_prev = 0;
        end else begin
            if (hs_prev) begin
                chk("idle_busy", busy, 1'b0);
                chk("idle_sready", start_ready, 1'b1);
            end
            hs_prev = 0;
            if (ren) begin
                chk("ren_inb", inb($signed(x_addr), $signed(y_addr)), 1'b1);
                chk("wen", wen, 1'b0);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1'b0, 1'b1);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc, sb[0].acc + 18);
                        seen = 1;
                    end
                    if (!out_ready) begin
                        chk("stall_c", center_px, sb[0].c);
                        chk("stall_r", ring_px, sb[0].r);
                        chk("stall_sready", start_ready, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("center", center_px, e.c);
                        chk("ring", ring_px, e.r);
                        last_c = center_px;
                        last_r = ring_px;
                        seen = 0;
                        hs_prev = 1;
                        last_hs = cyc + 1;
                    end
                end
            end
            if (start_valid && start_ready) begin
                if (b2b && n_b2b > 0)
                    chk("b2b_gap", cyc + 1 - last_hs, 1);
                if (b2b) n_b2b++;
                sb.push_back(model($signed(cx), $signed(cy), cyc + 1));
            end
        end
    end

    task automatic start(int x, int y);
        bit ok;
        ok = 0;
        cx = 5'(x);
        cy = 5'(y);
        start_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (start_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        start_valid = 1'b0;
        if (!ok) chk("start_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !busy) ok = 1;
        end
        if (!ok) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int nv;
        rst = 1'b1;
        start_valid = 1'b0;
        out_ready = 1'b1;
        cx = '0;
        cy = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ren", ren, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_oval", out_valid, 1'b0);
        chk("rst_center", center_px, 8'h00);
        chk("rst_ring", ring_px, 128'h0);
        chk("rst_sready", start_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_sready0", start_ready, 1'b1);

        // Interior center.
        start(8, 8);
        drain();
        chk("t1_center", last_c, 8'h88);
        chk("t1_ring1", last_r[7:0], 8'h58);
        chk("t1_ring5", last_r[39:32], 8'h8B);
        chk("t1_ring9", last_r[71:64], 8'hB8);
        chk("t1_ring13", last_r[103:96], 8'h85);

        // Top-left corner.
        start(0, 0);
        drain();
        chk("t2_center", last_c, 8'h00);
        chk("t2_ring1", last_r[7:0], 8'h00);
        chk("t2_ring5", last_r[39:32], 8'h03);
        chk("t2_ring9", last_r[71:64], 8'h30);
        chk("t2_ring13", last_r[103:96], 8'h00);

        // Bottom-right corner.
        start(15, 15);
        drain();
        chk("t3_ring5", last_r[39:32], 8'h00);
        chk("t3_ring9", last_r[71:64], 8'h00);
        chk("t3_ring13", last_r[103:96], 8'hFC);
        chk("t3_ring1", last_r[7:0], 8'hCF);

        // Consumer stall for 10 cycles.
        out_ready = 1'b0;
        start(3, 12);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (out_valid) ok = 1;
        end
        if (!ok) chk("t4_valid_timeout", 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a fetch.
        start(8, 8);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_ren", ren, 1'b0);
        chk("t5_busy", busy, 1'b0);
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("t5_no_valid", nv, 0);
        start(8, 8);
        drain();
        chk("t5_center", last_c, 8'h88);
        chk("t5_ring13", last_r[103:96], 8'h85);

        // Back-to-back fetches with start_valid held.
        b2b = 1;
        n_b2b = 0;
        cx = 5'd2;
        cy = 5'd9;
        start_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (n_b2b >= 2) ok = 1;
        end
        start_valid = 1'b0;
        if (!ok) chk("t6_timeout", 1'b0, 1'b1);
        drain();
        b2b = 0;
        chk("t6_count", n_b2b, 2);

        // A few random centers.
        for (int i = 0; i < 4; i++) begin
            start($urandom_range(15, 0), $urandom_range(15, 0));
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
